// File: rtl/anton_neopixel_stream_encoder_pkg.sv
// Shared definitions for the NeoPixel stream encoder.
//   BUFFER_END_DEFAULT  : default last valid byte index of the pixel buffer
//   T0H/T1H_STEPS_DEFAULT: high sub-steps for a '0' / '1' bit
//   PIXEL_BITS          : bits per transmitted GRB pixel
//   enc_state_t         : prefetch FSM states
//   expand_3to8/2to8    : RGB332 channel replication helpers
package anton_neopixel_stream_encoder_pkg;

  localparam int unsigned BUFFER_END_DEFAULT = 255;
  localparam int unsigned T0H_STEPS_DEFAULT  = 2;
  localparam int unsigned T1H_STEPS_DEFAULT  = 5;
  localparam int unsigned PIXEL_BITS         = 24;

  typedef enum logic [1:0] {
    ENC_STATE_IDLE = 2'd0,
    ENC_STATE_REQ  = 2'd1,
    ENC_STATE_FULL = 2'd2
  } enc_state_t;

  function automatic logic [7:0] expand_3to8(input logic [2:0] v);
    return {v, v, v[2:1]};
  endfunction

  function automatic logic [7:0] expand_2to8(input logic [1:0] v);
    return {v, v, v, v};
  endfunction

endpackage

// File: rtl/anton_neopixel_pixel_expand.sv
// Combinational pixel expander: buffer word -> 24-bit GRB pixel.
//   word       : 32-bit buffer read data
//   lane       : byte lane selecting the RGB332 byte in 8-bit mode
//   mode_32bit : 1 = word[23:0] is already GRB; 0 = RGB332 byte per pixel
//   grb        : expanded pixel, G in [23:16], R in [15:8], B in [7:0]
module anton_neopixel_pixel_expand
  import anton_neopixel_stream_encoder_pkg::*;
(
  input  logic [31:0]           word,
  input  logic [1:0]            lane,
  input  logic                  mode_32bit,
  output logic [PIXEL_BITS-1:0] grb
);

  logic [7:0] sel_byte;

  always_comb begin
    sel_byte = word[7:0];
    case (lane)
      2'd1:    sel_byte = word[15:8];
      2'd2:    sel_byte = word[23:16];
      2'd3:    sel_byte = word[31:24];
      default: sel_byte = word[7:0];
    endcase
    if (mode_32bit) begin
      grb = word[PIXEL_BITS-1:0];
    end else begin
      // RGB332 byte: R[7:5] G[4:2] B[1:0], emitted in GRB order
      grb = {expand_3to8(sel_byte[4:2]), expand_3to8(sel_byte[7:5]),
             expand_2to8(sel_byte[1:0])};
    end
  end

endmodule

// File: rtl/anton_neopixel_stream_encoder.sv
// NeoPixel stream encoder: prefetches the next pixel from the pixel buffer
// one pixel ahead, expands it to GRB and drives the one-wire waveform from
// the controller's sub-step / bit / pixel indices.
//   clk7mhz, rst           : 7 MHz clock, async active-high reset
//   reg_ctrl_32bit         : 1 = 32-bit word per pixel, 0 = RGB332 byte
//   stream_output/_reset   : controller transmitting / in latch gap
//   stream_bit_of          : last sub-step of the current pixel
//   bit_pattern_index      : sub-step 0-7; pixel_bit_index: bit 0-23
//   pixel_index(_max)      : current / last pixel byte index
//   buf_rd_req/addr/data/valid : pixel buffer read port
//   neo_out                : registered serial line
//   underrun               : sticky, next pixel missing at a boundary
// Optional macro ANTON_NEOPIXEL_ENCODER_UNDERRUN_CNT_EN adds
//   underrun_cnt[7:0]      : saturating underrun event count
module anton_neopixel_stream_encoder
  import anton_neopixel_stream_encoder_pkg::*;
#(
  parameter  int unsigned BUFFER_END  = BUFFER_END_DEFAULT,
  parameter  int unsigned T0H_STEPS   = T0H_STEPS_DEFAULT,
  parameter  int unsigned T1H_STEPS   = T1H_STEPS_DEFAULT,
  localparam int unsigned BUFFER_BITS = $clog2(BUFFER_END + 1)
) (
  input  logic                   clk7mhz,
  input  logic                   rst,
  input  logic                   reg_ctrl_32bit,
  input  logic                   stream_output,
  input  logic                   stream_reset,
  input  logic                   stream_bit_of,
  input  logic [2:0]             bit_pattern_index,
  input  logic [4:0]             pixel_bit_index,
  input  logic [BUFFER_BITS-1:0] pixel_index,
  input  logic [BUFFER_BITS-1:0] pixel_index_max,
  output logic                   buf_rd_req,
  output logic [BUFFER_BITS-3:0] buf_rd_addr,
  input  logic [31:0]            buf_rd_data,
  input  logic                   buf_rd_valid,
  output logic                   neo_out,
`ifdef ANTON_NEOPIXEL_ENCODER_UNDERRUN_CNT_EN
  output logic [7:0]             underrun_cnt,
`endif
  output logic                   underrun
);

  enc_state_t             state;
  logic [PIXEL_BITS-1:0]  cur_pixel;
  logic [PIXEL_BITS-1:0]  nxt_pixel;
  logic                   nxt_valid;
  logic                   prev_reset;
  logic [BUFFER_BITS-1:0] fetch_idx;

  logic [BUFFER_BITS-1:0] eff_idx;
  logic [BUFFER_BITS-1:0] next_idx;
  logic                   consume;
  logic [PIXEL_BITS-1:0]  fetched_grb;
  logic [4:0]             bit_sel;
  logic                   tx_bit;
  logic                   bit_high;

  anton_neopixel_pixel_expand u_expand (
    .word       (buf_rd_data),
    .lane       (fetch_idx[1:0]),
    .mode_32bit (reg_ctrl_32bit),
    .grb        (fetched_grb)
  );

  assign buf_rd_addr = fetch_idx[BUFFER_BITS-1:2];

  always_comb begin
    eff_idx  = reg_ctrl_32bit ? {pixel_index[BUFFER_BITS-1:2], 2'b11} : pixel_index;
    next_idx = (eff_idx == pixel_index_max) ? '0 :
               pixel_index + (reg_ctrl_32bit ? BUFFER_BITS'(4) : BUFFER_BITS'(1));
    consume  = stream_bit_of || (prev_reset && stream_output);
    bit_sel  = 5'(PIXEL_BITS - 1) - pixel_bit_index;
    tx_bit   = cur_pixel[bit_sel];
    bit_high = 32'(bit_pattern_index) < (tx_bit ? T1H_STEPS : T0H_STEPS);
  end

  // cur_pixel changes on the edge ending sub-step 7 / the first output cycle;
  // sub-step 0 is high for either bit value, so the stale pixel is harmless.
  always_ff @(posedge clk7mhz or posedge rst) begin
    if (rst) begin
      state      <= ENC_STATE_IDLE;
      cur_pixel  <= '0;
      nxt_pixel  <= '0;
      nxt_valid  <= 1'b0;
      prev_reset <= 1'b0;
      fetch_idx  <= '0;
      buf_rd_req <= 1'b0;
      neo_out    <= 1'b0;
      underrun   <= 1'b0;
`ifdef ANTON_NEOPIXEL_ENCODER_UNDERRUN_CNT_EN
      underrun_cnt <= '0;
`endif
    end else begin
      prev_reset <= stream_reset;
      neo_out    <= stream_output && bit_high;
      if (consume) begin
        if (nxt_valid) begin
          cur_pixel <= nxt_pixel;
        end else if (state == ENC_STATE_REQ && buf_rd_valid) begin
          // read data landing on the boundary goes straight out
          cur_pixel <= fetched_grb;
        end else begin
          cur_pixel <= '0;
          underrun  <= 1'b1;
`ifdef ANTON_NEOPIXEL_ENCODER_UNDERRUN_CNT_EN
          if (underrun_cnt != 8'hFF) underrun_cnt <= underrun_cnt + 8'd1;
`endif
        end
        // any outstanding read is abandoned; refetch from the new index
        nxt_valid  <= 1'b0;
        buf_rd_req <= 1'b0;
        state      <= ENC_STATE_IDLE;
      end else begin
        case (state)
          ENC_STATE_IDLE: begin
            if (!nxt_valid && (stream_output || stream_reset)) begin
              fetch_idx  <= stream_output ? next_idx : '0;
              buf_rd_req <= 1'b1;
              state      <= ENC_STATE_REQ;
            end
          end
          ENC_STATE_REQ: begin
            if (buf_rd_valid) begin
              nxt_pixel  <= fetched_grb;
              nxt_valid  <= 1'b1;
              buf_rd_req <= 1'b0;
              state      <= ENC_STATE_FULL;
            end
          end
          ENC_STATE_FULL: state <= ENC_STATE_FULL;
          default:        state <= ENC_STATE_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_anton_neopixel_stream_encoder.sv
module tb_anton_neopixel_stream_encoder;

  logic        clk7mhz = 1'b0;
  logic        rst;
  logic        reg_ctrl_32bit;
  logic        stream_output;
  logic        stream_reset;
  logic        stream_bit_of;
  logic [2:0]  bit_pattern_index;
  logic [4:0]  pixel_bit_index;
  logic [7:0]  pixel_index;
  logic [7:0]  pixel_index_max;
  logic        buf_rd_req;
  logic [5:0]  buf_rd_addr;
  logic [31:0] buf_rd_data;
  logic        buf_rd_valid;
  logic        neo_out;
  logic        underrun;
`ifdef ANTON_NEOPIXEL_ENCODER_UNDERRUN_CNT_EN
  logic [7:0]  underrun_cnt;
`endif

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [0:63];
  int          lat   = 0;
  bit          stall = 1'b0;
  bit          pend  = 1'b0;
  int          cnt   = 0;

  logic [23:0] exp_pix [0:3];
  logic [23:0] got_pix [0:3];
  int          shape_bad;
  bit          gap_req_seen;
  int          gap_addr_bad;

  always #5 clk7mhz = ~clk7mhz;

  anton_neopixel_stream_encoder #(
    .BUFFER_END (255),
    .T0H_STEPS  (2),
    .T1H_STEPS  (5)
  ) dut (
    .clk7mhz           (clk7mhz),
    .rst               (rst),
    .reg_ctrl_32bit    (reg_ctrl_32bit),
    .stream_output     (stream_output),
    .stream_reset      (stream_reset),
    .stream_bit_of     (stream_bit_of),
    .bit_pattern_index (bit_pattern_index),
    .pixel_bit_index   (pixel_bit_index),
    .pixel_index       (pixel_index),
    .pixel_index_max   (pixel_index_max),
    .buf_rd_req        (buf_rd_req),
    .buf_rd_addr       (buf_rd_addr),
    .buf_rd_data       (buf_rd_data),
    .buf_rd_valid      (buf_rd_valid),
    .neo_out           (neo_out),
`ifdef ANTON_NEOPIXEL_ENCODER_UNDERRUN_CNT_EN
    .underrun_cnt      (underrun_cnt),
`endif
    .underrun          (underrun)
  );

  // One clock: drive controller inputs and the buffer model, then wait for
  // the next falling edge, where outputs reflect this cycle's inputs.
  task automatic step(input logic so, input logic sr, input logic bof,
                      input logic [2:0] bpi, input logic [4:0] pbi,
                      input logic [7:0] pidx, input logic fv);
    stream_output     = so;
    stream_reset      = sr;
    stream_bit_of     = bof;
    bit_pattern_index = bpi;
    pixel_bit_index   = pbi;
    pixel_index       = pidx;
    buf_rd_valid      = 1'b0;
    if (buf_rd_req !== 1'b1) pend = 1'b0;
    else if (!pend) begin
      pend = 1'b1;
      cnt  = lat;
    end
    if (fv) begin
      buf_rd_valid = 1'b1;
      buf_rd_data  = mem[buf_rd_addr];
      pend         = 1'b0;
    end else if (pend && !stall) begin
      if (cnt == 0) begin
        buf_rd_valid = 1'b1;
        buf_rd_data  = mem[buf_rd_addr];
        pend         = 1'b0;
      end else cnt--;
    end
    @(negedge clk7mhz);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 3'd0, 5'd0, 8'd0, 1'b0);
  endtask

  // Latch gap followed by npix pixels; decodes each pixel from pulse widths
  // and counts samples deviating from the ideal waveform of exp_pix.
  task automatic run_frame(input int gap, input int npix, input bit m32,
                           input int stall_pix, input int force_pix);
    int   highs;
    logic eb;
    logic ev;
    reg_ctrl_32bit = m32;
    shape_bad      = 0;
    gap_req_seen   = 1'b0;
    gap_addr_bad   = 0;
    for (int g = 0; g < gap; g++) begin
      step(1'b0, 1'b1, 1'b0, 3'd0, 5'd0, 8'd0, 1'b0);
      if (neo_out !== 1'b0) shape_bad++;
      if (buf_rd_req === 1'b1) begin
        gap_req_seen = 1'b1;
        if (buf_rd_addr !== 6'd0) gap_addr_bad++;
      end
    end
    for (int p = 0; p < npix; p++) begin
      stall      = (p == stall_pix);
      got_pix[p] = '0;
      for (int b = 0; b < 24; b++) begin
        highs = 0;
        eb    = exp_pix[p][23-b];
        for (int s = 0; s < 8; s++) begin
          step(1'b1, 1'b0, (b == 23 && s == 7), 3'(s), 5'(b),
               m32 ? 8'(p * 4) : 8'(p), (p == force_pix) && (b == 23) && (s == 7));
          ev = (s < (eb ? 5 : 2));
          if (neo_out !== ev) shape_bad++;
          if (neo_out === 1'b1) highs++;
        end
        got_pix[p][23-b] = (highs >= 4);
      end
    end
    stall = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk7mhz);
    total++; if (neo_out !== 1'b0) begin bad++; $display("FAIL reset_neo got=%b want=0", neo_out); end
    total++; if (buf_rd_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b want=0", buf_rd_req); end
    total++; if (buf_rd_addr !== 6'd0) begin bad++; $display("FAIL reset_addr got=%h want=00", buf_rd_addr); end
    total++; if (underrun !== 1'b0) begin bad++; $display("FAIL reset_underrun got=%b want=0", underrun); end
`ifdef ANTON_NEOPIXEL_ENCODER_UNDERRUN_CNT_EN
    total++; if (underrun_cnt !== 8'd0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", underrun_cnt); end
`endif
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_32bit;
    pixel_index_max = 8'd7;
    lat = 0;
    mem[0] = 32'h7EFF0000;   // top byte must be ignored
    mem[1] = 32'h000000AA;
    exp_pix[0] = 24'hFF0000;
    exp_pix[1] = 24'h0000AA;
    run_frame(10, 2, 1'b1, -1, -1);
    idle(3);
    for (int p = 0; p < 2; p++) begin
      total++;
      if (got_pix[p] !== exp_pix[p]) begin
        bad++; $display("FAIL px32_%0d got=%h want=%h", p, got_pix[p], exp_pix[p]);
      end
    end
    total++; if (shape_bad !== 0) begin bad++; $display("FAIL shape32 got=%0d want=0", shape_bad); end
    total++; if (underrun !== 1'b0) begin bad++; $display("FAIL underrun32 got=%b want=0", underrun); end
    total++; if (neo_out !== 1'b0) begin bad++; $display("FAIL idle_neo got=%b want=0", neo_out); end
  endtask

  task automatic test_8bit;
    pixel_index_max = 8'd3;
    lat = 1;
    mem[0] = 32'h25E31C00;   // lanes: 00, 1C, E3, 25
    exp_pix[0] = 24'h000000;
    exp_pix[1] = 24'hFF0000;
    exp_pix[2] = 24'h00FFFF;
    exp_pix[3] = 24'h242455;
    run_frame(10, 4, 1'b0, -1, -1);
    idle(3);
    for (int p = 0; p < 4; p++) begin
      total++;
      if (got_pix[p] !== exp_pix[p]) begin
        bad++; $display("FAIL px8_%0d got=%h want=%h", p, got_pix[p], exp_pix[p]);
      end
    end
    total++; if (shape_bad !== 0) begin bad++; $display("FAIL shape8 got=%0d want=0", shape_bad); end
    total++; if (underrun !== 1'b0) begin bad++; $display("FAIL underrun8 got=%b want=0", underrun); end
  endtask

  task automatic test_coincident;
    pixel_index_max = 8'd7;
    lat = 0;
    mem[0] = 32'h00123456;
    mem[1] = 32'h0000C3A5;
    exp_pix[0] = 24'h123456;
    exp_pix[1] = 24'h00C3A5;
    run_frame(10, 2, 1'b1, 0, 0);
    idle(3);
    for (int p = 0; p < 2; p++) begin
      total++;
      if (got_pix[p] !== exp_pix[p]) begin
        bad++; $display("FAIL pxcoin_%0d got=%h want=%h", p, got_pix[p], exp_pix[p]);
      end
    end
    total++; if (underrun !== 1'b0) begin bad++; $display("FAIL underrun_coin got=%b want=0", underrun); end
  endtask

  task automatic test_wrap;
    pixel_index_max = 8'd7;
    lat = 4;
    mem[0] = 32'h0000A50F;
    mem[1] = 32'h003C3C3C;
    exp_pix[0] = 24'h00A50F;
    exp_pix[1] = 24'h3C3C3C;
    run_frame(12, 2, 1'b1, -1, -1);
    total++; if (got_pix[1] !== 24'h3C3C3C) begin bad++; $display("FAIL wrapA_1 got=%h want=3c3c3c", got_pix[1]); end
    mem[0] = 32'h005A5A5A;   // the gap fetch must pick up the new word
    exp_pix[0] = 24'h5A5A5A;
    run_frame(12, 2, 1'b1, -1, -1);
    idle(3);
    total++; if (gap_req_seen !== 1'b1) begin bad++; $display("FAIL wrap_gap_req got=%b want=1", gap_req_seen); end
    total++; if (gap_addr_bad !== 0) begin bad++; $display("FAIL wrap_gap_addr got=%0d want=0", gap_addr_bad); end
    total++; if (got_pix[0] !== 24'h5A5A5A) begin bad++; $display("FAIL wrapB_0 got=%h want=5a5a5a", got_pix[0]); end
    total++; if (got_pix[1] !== 24'h3C3C3C) begin bad++; $display("FAIL wrapB_1 got=%h want=3c3c3c", got_pix[1]); end
    total++; if (shape_bad !== 0) begin bad++; $display("FAIL shape_wrap got=%0d want=0", shape_bad); end
  endtask

  task automatic test_underrun;
    pixel_index_max = 8'd7;
    lat = 300;
    mem[0] = 32'h00FFFFFF;
    mem[1] = 32'h00FFFFFF;
    exp_pix[0] = 24'h000000;
    exp_pix[1] = 24'h000000;
    run_frame(10, 2, 1'b1, -1, -1);
    idle(3);
    for (int p = 0; p < 2; p++) begin
      total++;
      if (got_pix[p] !== 24'h000000) begin
        bad++; $display("FAIL pxund_%0d got=%h want=000000", p, got_pix[p]);
      end
    end
    total++; if (underrun !== 1'b1) begin bad++; $display("FAIL underrun_flag got=%b want=1", underrun); end
`ifdef ANTON_NEOPIXEL_ENCODER_UNDERRUN_CNT_EN
    total++; if (underrun_cnt !== 8'd3) begin bad++; $display("FAIL underrun_cnt got=%0d want=3", underrun_cnt); end
`endif
  endtask

  task automatic test_mid_reset;
    pixel_index_max = 8'd7;
    reg_ctrl_32bit  = 1'b1;
    lat = 0;
    mem[0] = 32'h00FF00FF;
    mem[1] = 32'h00000F0F;
    total++; if (underrun !== 1'b1) begin bad++; $display("FAIL sticky_underrun got=%b want=1", underrun); end
    for (int g = 0; g < 10; g++) step(1'b0, 1'b1, 1'b0, 3'd0, 5'd0, 8'd0, 1'b0);
    lat = 1000;
    for (int s = 0; s < 4; s++) step(1'b1, 1'b0, 1'b0, 3'(s), 5'd0, 8'd0, 1'b0);
    total++; if (neo_out !== 1'b1) begin bad++; $display("FAIL midbit_neo_pre got=%b want=1", neo_out); end
    total++; if (buf_rd_req !== 1'b1) begin bad++; $display("FAIL midbit_req_pre got=%b want=1", buf_rd_req); end
    #2 rst = 1'b1;
    #1;
    total++; if (neo_out !== 1'b0) begin bad++; $display("FAIL async_neo got=%b want=0", neo_out); end
    total++; if (buf_rd_req !== 1'b0) begin bad++; $display("FAIL async_req got=%b want=0", buf_rd_req); end
    total++; if (underrun !== 1'b0) begin bad++; $display("FAIL async_underrun got=%b want=0", underrun); end
    @(negedge clk7mhz);
    @(negedge clk7mhz);
    rst = 1'b0;
    lat = 0;
    exp_pix[0] = 24'hFF00FF;
    exp_pix[1] = 24'h000F0F;
    run_frame(10, 2, 1'b1, -1, -1);
    idle(3);
    for (int p = 0; p < 2; p++) begin
      total++;
      if (got_pix[p] !== exp_pix[p]) begin
        bad++; $display("FAIL pxrestart_%0d got=%h want=%h", p, got_pix[p], exp_pix[p]);
      end
    end
    total++; if (underrun !== 1'b0) begin bad++; $display("FAIL underrun_restart got=%b want=0", underrun); end
  endtask

  initial begin
    rst               = 1'b1;
    reg_ctrl_32bit    = 1'b1;
    stream_output     = 1'b0;
    stream_reset      = 1'b0;
    stream_bit_of     = 1'b0;
    bit_pattern_index = 3'd0;
    pixel_bit_index   = 5'd0;
    pixel_index       = 8'd0;
    pixel_index_max   = 8'd7;
    buf_rd_data       = 32'd0;
    buf_rd_valid      = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
    test_reset;
    test_32bit;
    test_8bit;
    test_coincident;
    test_wrap;
    test_underrun;
    test_mid_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
